// File: rtl/flit_rank_stage.sv
// flit_rank_stage
//   Input pipeline of the bufferless router, directly upstream of swAlloc.
//   Stage A latches the four link flits, ages them (saturating) and merges one
//   local injection into the lowest free slot. A 3-layer compare-swap network
//   sorts the stage-A registers oldest-first, and stage B registers the
//   rank-ordered result. Latency is 2 edges with full throughput.
//
//   Optional feature: define RANK_GOLDEN_EN to enable golden-epoch ranking.
//   A rotating golden source id then outranks every non-golden flit.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   in_valid/flit/ppv/age/src   four link slots (slot i at index i)
//   inj_valid/flit/ppv/src      local injection request
//   inj_ready          injection accepted this cycle (combinational)
//   numFlit_out        number of valid ranked flits (0..4)
//   rank_valid         bit r set when rank r holds a flit
//   ppv_0..ppv_3       productive-port vectors of ranks 0..3
//   rank_flit/age/slot payload, age and original slot index per rank

`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 3
`endif

module flit_rank_stage #(
  parameter int unsigned FLIT_W       = 64,
  parameter int unsigned AGE_W        = 8,
  parameter int unsigned SRC_W        = 6,
  parameter int unsigned GOLDEN_EPOCH = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     in_valid,
  input  logic [4*FLIT_W-1:0]            in_flit,
  input  logic [4*(`NUM_PORT-1)-1:0]     in_ppv,
  input  logic [4*AGE_W-1:0]             in_age,
  input  logic [4*SRC_W-1:0]             in_src,
  input  logic                           inj_valid,
  input  logic [FLIT_W-1:0]              inj_flit,
  input  logic [`NUM_PORT-2:0]           inj_ppv,
  input  logic [SRC_W-1:0]               inj_src,
  output logic                           inj_ready,
  output logic [`PC_INDEX_WIDTH-1:0]     numFlit_out,
  output logic [3:0]                     rank_valid,
  output logic [`NUM_PORT-2:0]           ppv_0,
  output logic [`NUM_PORT-2:0]           ppv_1,
  output logic [`NUM_PORT-2:0]           ppv_2,
  output logic [`NUM_PORT-2:0]           ppv_3,
  output logic [4*FLIT_W-1:0]            rank_flit,
  output logic [4*AGE_W-1:0]             rank_age,
  output logic [7:0]                     rank_slot
);

  localparam int unsigned PPV_W = `NUM_PORT - 1;
  localparam int unsigned CNT_W = `PC_INDEX_WIDTH;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef struct packed {
    logic              valid;
    logic              golden;
    logic [AGE_W-1:0]  age;
    logic [1:0]        slot;
    logic [PPV_W-1:0]  ppv;
    logic [FLIT_W-1:0] flit;
  } entryT;

`ifdef RANK_GOLDEN_EN
  localparam int unsigned EPOCH_W = (GOLDEN_EPOCH > 1) ? $clog2(GOLDEN_EPOCH) : 1;

  logic [EPOCH_W-1:0] epochCnt;
  logic [SRC_W-1:0]   goldenId;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epochCnt <= '0;
      goldenId <= '0;
    end else if (epochCnt == EPOCH_W'(GOLDEN_EPOCH - 1)) begin
      epochCnt <= '0;
      goldenId <= goldenId + 1'b1;
    end else begin
      epochCnt <= epochCnt + 1'b1;
    end
  end
`else
  logic unusedSrc;
  assign unusedSrc = ^{in_src, inj_src};
`endif

  // Injection
  logic       injTake;
  logic [3:0] injOneHot;

  assign inj_ready = ~reset & (in_valid != 4'hF);
  assign injTake   = inj_valid & inj_ready;
  // ~v & (v+1) isolates the lowest clear bit: the lowest free slot.
  assign injOneHot = ~in_valid & (in_valid + 4'd1);

  // Stage A capture
  entryT capA [4];
  entryT stA  [4];

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      capA[i]      = '0;
      capA[i].slot = 2'(i);
      if (in_valid[i]) begin
        capA[i].valid = 1'b1;
        capA[i].age   = (in_age[i*AGE_W +: AGE_W] == AGE_MAX) ?
                        AGE_MAX : in_age[i*AGE_W +: AGE_W] + 1'b1;
        capA[i].ppv   = in_ppv[i*PPV_W +: PPV_W];
        capA[i].flit  = in_flit[i*FLIT_W +: FLIT_W];
`ifdef RANK_GOLDEN_EN
        capA[i].golden = (in_src[i*SRC_W +: SRC_W] == goldenId);
`endif
      end else if (injTake && injOneHot[i]) begin
        capA[i].valid = 1'b1;
        capA[i].ppv   = inj_ppv;
        capA[i].flit  = inj_flit;
`ifdef RANK_GOLDEN_EN
        capA[i].golden = (inj_src == goldenId);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) stA[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) stA[i] <= capA[i];
    end
  end

  // Sort network: (0,1)(2,3) / (0,2)(1,3) / (1,2)
  // Slot index is the final tiebreak, so the key order is total and stable.
  function automatic logic beats(input entryT a, input entryT b);
    if (a.valid != b.valid)   return a.valid;
    if (a.golden != b.golden) return a.golden;
    if (a.age != b.age)       return a.age > b.age;
    return a.slot < b.slot;
  endfunction

  entryT l1 [4];
  entryT l2 [4];
  entryT l3 [4];
  logic  s01, s23, s02, s13, s12;

  always_comb begin
    s01   = beats(stA[1], stA[0]);
    s23   = beats(stA[3], stA[2]);
    l1[0] = s01 ? stA[1] : stA[0];
    l1[1] = s01 ? stA[0] : stA[1];
    l1[2] = s23 ? stA[3] : stA[2];
    l1[3] = s23 ? stA[2] : stA[3];

    s02   = beats(l1[2], l1[0]);
    s13   = beats(l1[3], l1[1]);
    l2[0] = s02 ? l1[2] : l1[0];
    l2[2] = s02 ? l1[0] : l1[2];
    l2[1] = s13 ? l1[3] : l1[1];
    l2[3] = s13 ? l1[1] : l1[3];

    s12   = beats(l2[2], l2[1]);
    l3[0] = l2[0];
    l3[1] = s12 ? l2[2] : l2[1];
    l3[2] = s12 ? l2[1] : l2[2];
    l3[3] = l2[3];
  end

  logic [CNT_W-1:0] sortCount;

  always_comb begin
    sortCount = '0;
    for (int unsigned r = 0; r < 4; r++) sortCount = sortCount + CNT_W'(l3[r].valid);
  end

  // Stage B
  logic [PPV_W-1:0] rankPpv [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      numFlit_out <= '0;
      rank_valid  <= '0;
      rank_flit   <= '0;
      rank_age    <= '0;
      rank_slot   <= '0;
      for (int unsigned r = 0; r < 4; r++) rankPpv[r] <= '0;
    end else begin
      numFlit_out <= sortCount;
      for (int unsigned r = 0; r < 4; r++) begin
        rank_valid[r]                <= l3[r].valid;
        rank_slot[r*2 +: 2]          <= l3[r].slot;
        rank_flit[r*FLIT_W +: FLIT_W] <= l3[r].valid ? l3[r].flit : '0;
        rank_age[r*AGE_W +: AGE_W]   <= l3[r].valid ? l3[r].age  : '0;
        rankPpv[r]                   <= l3[r].valid ? l3[r].ppv  : '0;
      end
    end
  end

  assign ppv_0 = rankPpv[0];
  assign ppv_1 = rankPpv[1];
  assign ppv_2 = rankPpv[2];
  assign ppv_3 = rankPpv[3];

endmodule

// File: tb/tb_flit_rank_stage.sv
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 3
`endif

module tb_flit_rank_stage;

  localparam int unsigned FW = 64;
  localparam int unsigned AW = 8;
  localparam int unsigned SW = 6;
  localparam int unsigned PW = `NUM_PORT - 1;
  localparam int unsigned CW = `PC_INDEX_WIDTH;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        in_valid;
  logic [4*FW-1:0]   in_flit;
  logic [4*PW-1:0]   in_ppv;
  logic [4*AW-1:0]   in_age;
  logic [4*SW-1:0]   in_src;
  logic              inj_valid;
  logic [FW-1:0]     inj_flit;
  logic [PW-1:0]     inj_ppv;
  logic [SW-1:0]     inj_src;
  logic              inj_ready;
  logic [CW-1:0]     numFlit_out;
  logic [3:0]        rank_valid;
  logic [PW-1:0]     ppv_0, ppv_1, ppv_2, ppv_3;
  logic [4*FW-1:0]   rank_flit;
  logic [4*AW-1:0]   rank_age;
  logic [7:0]        rank_slot;

  logic [PW-1:0]     ppvOut [4];
  assign ppvOut[0] = ppv_0;
  assign ppvOut[1] = ppv_1;
  assign ppvOut[2] = ppv_2;
  assign ppvOut[3] = ppv_3;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  localparam logic [FW-1:0] F0 = 64'hA000_0000_0000_0010;
  localparam logic [FW-1:0] F1 = 64'hA000_0000_0000_0011;
  localparam logic [FW-1:0] F2 = 64'hA000_0000_0000_0012;
  localparam logic [FW-1:0] F3 = 64'hA000_0000_0000_0013;
  localparam logic [FW-1:0] FI = 64'hC0DE_0000_1234_5678;
  localparam logic [FW-1:0] H0 = 64'hB000_0000_0000_0020;
  localparam logic [FW-1:0] H1 = 64'hB000_0000_0000_0021;
  localparam logic [FW-1:0] H2 = 64'hB000_0000_0000_0022;
  localparam logic [FW-1:0] H3 = 64'hB000_0000_0000_0023;

`ifdef RANK_GOLDEN_EN
  flit_rank_stage #(.FLIT_W(FW), .AGE_W(AW), .SRC_W(SW), .GOLDEN_EPOCH(4)) dut (
`else
  flit_rank_stage #(.FLIT_W(FW), .AGE_W(AW), .SRC_W(SW)) dut (
`endif
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_flit(in_flit), .in_ppv(in_ppv),
    .in_age(in_age), .in_src(in_src),
    .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ppv(inj_ppv), .inj_src(inj_src),
    .inj_ready(inj_ready), .numFlit_out(numFlit_out), .rank_valid(rank_valid),
    .ppv_0(ppv_0), .ppv_1(ppv_1), .ppv_2(ppv_2), .ppv_3(ppv_3),
    .rank_flit(rank_flit), .rank_age(rank_age), .rank_slot(rank_slot)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All link sources share one id so golden selection never reorders
  // anything outside the dedicated golden step.
  task automatic clearInputs();
    in_valid  = '0;
    in_flit   = '0;
    in_ppv    = '0;
    in_age    = '0;
    in_src    = {4{6'h3F}};
    inj_valid = 1'b0;
    inj_flit  = '0;
    inj_ppv   = '0;
    inj_src   = 6'h3F;
  endtask

  task automatic setLink(input int i, input logic [FW-1:0] f, input logic [PW-1:0] p,
                         input logic [AW-1:0] a);
    in_valid[i]          = 1'b1;
    in_flit[i*FW +: FW]  = f;
    in_ppv[i*PW +: PW]   = p;
    in_age[i*AW +: AW]   = a;
  endtask

  task automatic checkSummary(input string tag, input logic [CW-1:0] num, input logic [3:0] valid);
    check({tag, "_num"}, 256'(numFlit_out), 256'(num));
    check({tag, "_valid"}, 256'(rank_valid), 256'(valid));
  endtask

  task automatic checkRank(input string tag, input int r, input logic [1:0] slot,
                           input logic [AW-1:0] age, input logic [FW-1:0] flit,
                           input logic [PW-1:0] ppv);
    check($sformatf("%s_r%0d_slot", tag, r), 256'(rank_slot[r*2 +: 2]), 256'(slot));
    check($sformatf("%s_r%0d_age", tag, r), 256'(rank_age[r*AW +: AW]), 256'(age));
    check($sformatf("%s_r%0d_flit", tag, r), 256'(rank_flit[r*FW +: FW]), 256'(flit));
    check($sformatf("%s_r%0d_ppv", tag, r), 256'(ppvOut[r]), 256'(ppv));
  endtask

  task automatic checkEmptyRank(input string tag, input int r);
    check($sformatf("%s_r%0d_age0", tag, r), 256'(rank_age[r*AW +: AW]), 256'(0));
    check($sformatf("%s_r%0d_flit0", tag, r), 256'(rank_flit[r*FW +: FW]), 256'(0));
    check($sformatf("%s_r%0d_ppv0", tag, r), 256'(ppvOut[r]), 256'(0));
  endtask

  initial begin
    // Reset held with random inputs
    reset     = 1'b1;
    in_valid  = 4'($urandom);
    in_flit   = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
    in_ppv    = 16'($urandom);
    in_age    = $urandom();
    in_src    = 24'($urandom);
    inj_valid = 1'b1;
    inj_flit  = {$urandom(), $urandom()};
    inj_ppv   = 4'($urandom);
    inj_src   = 6'($urandom);
    tick();
    tick();
    check("rst_inj_ready", 256'(inj_ready), 256'(0));
    checkSummary("rst", 0, 4'b0000);
    check("rst_flit", 256'(rank_flit), 256'(0));
    check("rst_age", 256'(rank_age), 256'(0));
    check("rst_slot", 256'(rank_slot), 256'(0));
    check("rst_ppv", 256'({ppv_0, ppv_1, ppv_2, ppv_3}), 256'(0));

    // Ages {5,9,9,2}, released from reset together
    clearInputs();
    setLink(0, F0, 4'h1, 8'd5);
    setLink(1, F1, 4'h2, 8'd9);
    setLink(2, F2, 4'h4, 8'd9);
    setLink(3, F3, 4'h8, 8'd2);
    reset = 1'b0;
    tick();
    checkSummary("lat1", 0, 4'b0000);
    clearInputs();
    tick();
    checkSummary("age", 4, 4'b1111);
    checkRank("age", 0, 2'd1, 8'd10, F1, 4'h2);
    checkRank("age", 1, 2'd2, 8'd10, F2, 4'h4);
    checkRank("age", 2, 2'd0, 8'd6,  F0, 4'h1);
    checkRank("age", 3, 2'd3, 8'd3,  F3, 4'h8);

    // Injection into free slot 0 with links on slots 1 and 3
    clearInputs();
    setLink(1, F1, 4'h2, 8'd3);
    setLink(3, F3, 4'h8, 8'd7);
    inj_valid = 1'b1;
    inj_flit  = FI;
    inj_ppv   = 4'h5;
    #1;
    check("inj_ready_1010", 256'(inj_ready), 256'(1));
    tick();
    clearInputs();
    tick();
    checkSummary("inj", 3, 4'b0111);
    checkRank("inj", 0, 2'd3, 8'd8, F3, 4'h8);
    checkRank("inj", 1, 2'd1, 8'd4, F1, 4'h2);
    checkRank("inj", 2, 2'd0, 8'd0, FI, 4'h5);
    checkEmptyRank("inj", 3);

    // Full links refuse injection; back-to-back sets, equal ages keep slot order
    clearInputs();
    setLink(0, F0, 4'h1, 8'd0);
    setLink(1, F1, 4'h2, 8'd0);
    setLink(2, F2, 4'h4, 8'd0);
    setLink(3, F3, 4'h8, 8'd0);
    inj_valid = 1'b1;
    inj_flit  = FI;
    inj_ppv   = 4'hF;
    #1;
    check("inj_ready_full_a", 256'(inj_ready), 256'(0));
    tick();
    setLink(0, H0, 4'h8, 8'd4);
    setLink(1, H1, 4'h4, 8'd4);
    setLink(2, H2, 4'h2, 8'd4);
    setLink(3, H3, 4'h1, 8'd4);
    #1;
    check("inj_ready_full_b", 256'(inj_ready), 256'(0));
    tick();
    checkSummary("fullA", 4, 4'b1111);
    checkRank("fullA", 0, 2'd0, 8'd1, F0, 4'h1);
    checkRank("fullA", 1, 2'd1, 8'd1, F1, 4'h2);
    checkRank("fullA", 2, 2'd2, 8'd1, F2, 4'h4);
    checkRank("fullA", 3, 2'd3, 8'd1, F3, 4'h8);
    clearInputs();
    tick();
    checkSummary("fullB", 4, 4'b1111);
    checkRank("fullB", 0, 2'd0, 8'd5, H0, 4'h8);
    checkRank("fullB", 1, 2'd1, 8'd5, H1, 4'h4);
    checkRank("fullB", 2, 2'd2, 8'd5, H2, 4'h2);
    checkRank("fullB", 3, 2'd3, 8'd5, H3, 4'h1);

    // Age saturation: 255 holds, 254 reaches 255 and ties on slot
    clearInputs();
    setLink(2, F2, 4'h4, 8'd255);
    setLink(3, F3, 4'h8, 8'd254);
    inj_valid = 1'b1;
    inj_flit  = FI;
    inj_ppv   = 4'h5;
    tick();
    clearInputs();
    tick();
    checkSummary("sat", 3, 4'b0111);
    checkRank("sat", 0, 2'd2, 8'd255, F2, 4'h4);
    checkRank("sat", 1, 2'd3, 8'd255, F3, 4'h8);
    checkRank("sat", 2, 2'd0, 8'd0,   FI, 4'h5);

    // Injection only
    clearInputs();
    inj_valid = 1'b1;
    inj_flit  = FI;
    inj_ppv   = 4'h6;
    tick();
    clearInputs();
    tick();
    checkSummary("injonly", 1, 4'b0001);
    checkRank("injonly", 0, 2'd0, 8'd0, FI, 4'h6);
    checkEmptyRank("injonly", 1);

    // Nothing valid
    tick();
    checkSummary("empty", 0, 4'b0000);
    check("empty_ppv", 256'({ppv_0, ppv_1, ppv_2, ppv_3}), 256'(0));
    check("empty_flit", 256'(rank_flit), 256'(0));

    // Reset mid-operation flushes both stages
    clearInputs();
    setLink(0, F0, 4'h1, 8'd1);
    setLink(1, F1, 4'h2, 8'd1);
    tick();
    tick();
    checkSummary("pre_rst", 2, 4'b0011);
    reset = 1'b1;
    #1;
    checkSummary("async_rst", 0, 4'b0000);
    tick();
    clearInputs();
    setLink(1, F1, 4'h2, 8'd0);
    reset = 1'b0;
    tick();
    checkSummary("post_rst1", 0, 4'b0000);
    clearInputs();
    tick();
    checkSummary("post_rst2", 1, 4'b0001);
    checkRank("post_rst2", 0, 2'd1, 8'd1, F1, 4'h2);

`ifdef RANK_GOLDEN_EN
    // Epoch of 4 cycles: golden id becomes 1 after the fourth edge
    reset = 1'b1;
    clearInputs();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    tick();
    setLink(0, F0, 4'h1, 8'd200);
    setLink(3, F3, 4'h8, 8'd0);
    in_src[0*SW +: SW] = 6'd3;
    in_src[3*SW +: SW] = 6'd1;
    tick();
    clearInputs();
    tick();
    checkSummary("golden", 2, 4'b0011);
    checkRank("golden", 0, 2'd3, 8'd1,   F3, 4'h8);
    checkRank("golden", 1, 2'd0, 8'd201, F0, 4'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
